// File: rtl/if_id_buffer.sv
// IF/ID decoupling FIFO: queues {instr, pcPlus4} pairs between fetch and decode.
// Optional macro DELAY_SLOT_EN: flush keeps one entry (branch delay slot) instead of emptying.
module if_id_buffer #(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    input  logic [31:0]                in_pcPlus4,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic [31:0]                out_pcPlus4,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ready_en_q, ready_en_d;
    logic [63:0]   mem_q [DEPTH];
    logic [63:0]   mem_d [DEPTH];
    logic          push, pop;
    logic [CW-1:0] remain;

    // Handshake: a word moves on a side only when valid and ready are both high
    // at the rising edge; in_ready depends on registered state only, never on out_ready.
    assign in_ready  = ready_en_q && (count_q < DEPTH_C);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign count     = count_q;

    assign out_instr   = out_valid ? mem_q[rd_ptr_q][63:32] : NOP_INSTR;
    assign out_pcPlus4 = out_valid ? mem_q[rd_ptr_q][31:0]  : 32'h0;

    always_comb begin
        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        ready_en_d = 1'b1;
        remain     = count_q - CW'(pop);

        if (flush) begin
`ifdef DELAY_SLOT_EN
            // Oldest surviving entry (or the incoming word) becomes the sole head.
            rd_ptr_d = rd_ptr_q + PW'(pop);
            if (remain != '0) begin
                wr_ptr_d = rd_ptr_d + PW'(1);
                count_d  = CW'(1);
            end else if (push) begin
                mem_d[wr_ptr_q] = {in_instr, in_pcPlus4};
                wr_ptr_d        = rd_ptr_d + PW'(1);
                count_d         = CW'(1);
            end else begin
                wr_ptr_d = rd_ptr_d;
                count_d  = '0;
            end
`else
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
`endif
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {in_instr, in_pcPlus4};
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            ready_en_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            ready_en_q <= ready_en_d;
            mem_q      <= mem_d;
        end
    end
endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer against a queue-based reference model.
module tb_if_id_buffer;
    localparam int DEPTH = 2;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pcPlus4;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pcPlus4;
    logic        flush;
    logic [1:0]  count;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] exp_q[$];
    bit          ready_en_m = 0;

    if_id_buffer #(.DEPTH(DEPTH), .NOP_INSTR(32'h0)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pcPlus4(in_pcPlus4),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pcPlus4(out_pcPlus4),
        .flush(flush), .count(count)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // Drive one cycle and advance the model by the behavioural rules.
    task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                         input bit ordy, input bit fl);
        bit          push_m, pop_m;
        logic [63:0] w, gone;
        @(negedge clk);
        in_valid = v; in_instr = ins; in_pcPlus4 = pc; out_ready = ordy; flush = fl;
        push_m = v && ready_en_m && (exp_q.size() < DEPTH);
        pop_m  = ordy && (exp_q.size() > 0);
        w      = {ins, pc};
        @(posedge clk);
        #1;
        if (pop_m) gone = exp_q.pop_front();
        if (fl) begin
`ifdef DELAY_SLOT_EN
            if (exp_q.size() > 0) begin
                w = exp_q[0];
                exp_q.delete();
                exp_q.push_back(w);
            end else if (push_m) begin
                exp_q.push_back(w);
            end
`else
            exp_q.delete();
`endif
        end else if (push_m) begin
            exp_q.push_back(w);
        end
        ready_en_m = 1;
    endtask

    task automatic drain();
        repeat (DEPTH + 1) drive(0, 32'h0, 32'h0, 1, 0);
        n_checks++;
        if (count !== 2'd0) begin
            n_errors++; $display("FAIL drain_count: got %0d expected 0", count);
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_errors++; $display("FAIL release_ready_low: got %b expected 0", in_ready);
        end
        @(posedge clk);
        #1;
        ready_en_m = 1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++; $display("FAIL release_ready_high: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_reset();
        reset = 0; in_valid = 0; in_instr = 0; in_pcPlus4 = 0; out_ready = 0; flush = 0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++;
        if (count !== 2'd0) begin n_errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++;
        if (out_instr !== 32'h0 || out_pcPlus4 !== 32'h0) begin
            n_errors++; $display("FAIL reset_out_data: got %h/%h expected 0/0", out_instr, out_pcPlus4);
        end
        release_reset();
    endtask

    task automatic test_first_push();
        drive(1, 32'h3c010001, 32'h3004, 0, 0);
        n_checks++;
        if (out_valid !== 1'b1 || count !== 2'd1) begin
            n_errors++; $display("FAIL first_push_valid_count: got %b/%0d expected 1/1", out_valid, count);
        end
        n_checks++;
        if (out_instr !== 32'h3c010001 || out_pcPlus4 !== 32'h3004) begin
            n_errors++; $display("FAIL first_push_data: got %h/%h expected 3c010001/3004", out_instr, out_pcPlus4);
        end
    endtask

    task automatic test_fill();
        drive(1, 32'h8c220004, 32'h3008, 0, 0);
        n_checks++;
        if (count !== 2'd2 || in_ready !== 1'b0) begin
            n_errors++; $display("FAIL fill_full: got count %0d ready %b expected 2/0", count, in_ready);
        end
        drive(1, 32'h00431020, 32'h300c, 0, 0);
        n_checks++;
        if (count !== 2'd2 || out_instr !== 32'h3c010001) begin
            n_errors++; $display("FAIL fill_hold: got count %0d head %h expected 2/3c010001", count, out_instr);
        end
    endtask

    task automatic test_stream();
        logic [31:0] ins;
        for (int i = 0; i < 8; i++) begin
            ins = $urandom;
            drive(1, ins, 32'h4000 + 32'(i * 4), 1, 0);
            n_checks++;
            if (count !== 2'(exp_q.size()) || count > 2'd2) begin
                n_errors++; $display("FAIL stream_count: got %0d expected %0d", count, exp_q.size());
            end
            n_checks++;
            if (exp_q.size() > 0 && (out_instr !== exp_q[0][63:32] || out_pcPlus4 !== exp_q[0][31:0])) begin
                n_errors++; $display("FAIL stream_head: got %h/%h expected %h/%h",
                                     out_instr, out_pcPlus4, exp_q[0][63:32], exp_q[0][31:0]);
            end
        end
    endtask

    task automatic test_flush();
        drain();
        drive(1, 32'haaaa0001, 32'h5004, 0, 0);
        drive(1, 32'hbbbb0002, 32'h5008, 0, 0);
        drive(1, 32'hcccc0003, 32'h500c, 0, 1);
`ifdef DELAY_SLOT_EN
        n_checks++;
        if (count !== 2'd1 || out_instr !== 32'haaaa0001) begin
            n_errors++; $display("FAIL flush_keep_a: got count %0d head %h expected 1/aaaa0001", count, out_instr);
        end
`else
        n_checks++;
        if (count !== 2'd0 || out_instr !== 32'h0 || out_valid !== 1'b0) begin
            n_errors++; $display("FAIL flush_empty: got count %0d head %h valid %b expected 0/0/0", count, out_instr, out_valid);
        end
`endif
        drive(0, 32'h0, 32'h0, 0, 0);
        n_checks++;
        if (in_ready !== (exp_q.size() < DEPTH)) begin
            n_errors++; $display("FAIL flush_ready: got %b expected %b", in_ready, exp_q.size() < DEPTH);
        end
    endtask

    task automatic test_flush_pop();
        drain();
        drive(1, 32'haaaa0001, 32'h6004, 0, 0);
        drive(1, 32'hbbbb0002, 32'h6008, 0, 0);
        drive(0, 32'h0, 32'h0, 1, 1);
`ifdef DELAY_SLOT_EN
        n_checks++;
        if (count !== 2'd1 || out_instr !== 32'hbbbb0002 || out_pcPlus4 !== 32'h6008) begin
            n_errors++; $display("FAIL flush_pop_keep_b: got count %0d head %h expected 1/bbbb0002", count, out_instr);
        end
`else
        n_checks++;
        if (count !== 2'd0 || out_valid !== 1'b0) begin
            n_errors++; $display("FAIL flush_pop_empty: got count %0d valid %b expected 0/0", count, out_valid);
        end
`endif
        drain();
        drive(1, 32'hdddd0004, 32'h6010, 0, 1);
        n_checks++;
        if (count !== 2'(exp_q.size())) begin
            n_errors++; $display("FAIL flush_push_empty: got count %0d expected %0d", count, exp_q.size());
        end
    endtask

    task automatic test_random();
        bit v, r, f;
        logic [31:0] exp_i, exp_p;
        for (int i = 0; i < 300; i++) begin
            v = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            f = ($urandom_range(0, 9) == 0);
            drive(v, $urandom, $urandom, r, f);
            exp_i = (exp_q.size() > 0) ? exp_q[0][63:32] : 32'h0;
            exp_p = (exp_q.size() > 0) ? exp_q[0][31:0]  : 32'h0;
            n_checks++;
            if (count !== 2'(exp_q.size())) begin
                n_errors++; $display("FAIL rand_count[%0d]: got %0d expected %0d", i, count, exp_q.size());
            end
            n_checks++;
            if (out_valid !== (exp_q.size() != 0) || in_ready !== (exp_q.size() < DEPTH)) begin
                n_errors++; $display("FAIL rand_flags[%0d]: got valid %b ready %b expected %b/%b", i,
                                     out_valid, in_ready, exp_q.size() != 0, exp_q.size() < DEPTH);
            end
            n_checks++;
            if (out_instr !== exp_i || out_pcPlus4 !== exp_p) begin
                n_errors++; $display("FAIL rand_head[%0d]: got %h/%h expected %h/%h", i, out_instr, out_pcPlus4, exp_i, exp_p);
            end
        end
    endtask

    task automatic test_reset_mid();
        drain();
        drive(1, 32'h11110001, 32'h7004, 0, 0);
        drive(1, 32'h22220002, 32'h7008, 0, 0);
        n_checks++;
        if (count !== 2'd2) begin
            n_errors++; $display("FAIL mid_reset_pre: got %0d expected 2", count);
        end
        @(negedge clk);
        in_valid = 1; out_ready = 0; flush = 0;
        #2;
        reset = 0;
        #1;
        exp_q.delete();
        ready_en_m = 0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || count !== 2'd0) begin
            n_errors++; $display("FAIL mid_reset_async: got valid %b ready %b count %0d expected 0/0/0",
                                 out_valid, in_ready, count);
        end
        in_valid = 0;
        @(posedge clk);
        release_reset();
        drive(0, 32'h0, 32'h0, 0, 0);
        n_checks++;
        if (count !== 2'd0 || out_valid !== 1'b0) begin
            n_errors++; $display("FAIL mid_reset_after: got count %0d valid %b expected 0/0", count, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_first_push();
        test_fill();
        test_stream();
        test_flush();
        test_flush_pop();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
